meas_ascii_formatter: RTL
=========================

// Module: meas_ascii_formatter
// PURPOSE
//  Upstream neighbour of the UART transmitter in the multimeter datapath.
//  Takes a signed millivolt sample, converts it with a sequential double-dabble,
//  and packs the result as an ASCII frame "sDD.DDD<TERM>" (sign, 2 int, point, 3 frac).
//  Presents the frame on a CHAR_NR*8 bus and strobes the UART only while it is idle.
// PARAMETERS
//  DATA_W     16     sample width, signed two's complement, LSB = 1 mV (only 16 supported)
//  CHAR_NR    8      frame length in chars; must be 8; char0 occupies bits [7:0], sent first
//  TERM_CHAR  8'h0A  last character of every frame (LF)
// PORTS
//  clk                  in   1         system clock
//  rst                  in   1         synchronous reset, active-high
//  sample_i             in   DATA_W    signed sample, mV
//  sample_valid_i       in   1         sample_i valid this cycle
//  ready_o              out  1         block accepts a sample this cycle
//  uart_busy_i          in   1         UART transmitter busy flag
//  clr_i                in   1         synchronous abort / clear
//  char_array_o         out  CHAR_NR*8 ASCII frame to the UART
//  char_array_update_o  out  1         one-cycle start strobe to the UART
//  drop_cnt_o           out  8         samples dropped while not ready, saturating
// BEHAVIOUR
//  Reset (rst=1 at an edge): state IDLE, ready_o=1, update=0, drop_cnt_o=0,
//    char_array_o="+00.000"+TERM (char0='+' .. char7=TERM).
//  Accept: sample_valid_i & ready_o at an edge -> latch sample, go ABS.
//  ready_o = (state==IDLE), decoded combinationally from the state register.
//  States and transitions:
//    IDLE -> ABS on accept.
//    ABS (1 cycle): sign flag = sample MSB; mag = |sample| as DATA_W unsigned
//      (-32768 -> 32768, no overflow); -> CONV.
//    CONV: exactly DATA_W iterations; each iteration adds 3 to every 20-bit
//      BCD nibble >=5, then shifts the BCD register left by one with the next
//      magnitude bit; -> PACK.
//    PACK (1 cycle): build frame in a shadow register.
//      char0 = '-' if negative, else '+'. Zero is always '+'.
//      char1..2 = d4 d3; char3 = '.'; char4..6 = d2 d1 d0; char7 = TERM_CHAR.
//      digit -> 8'h30+d. Leading zeros are kept. -> WAIT_TX.
//    WAIT_TX: hold while uart_busy_i=1. When uart_busy_i=0 at an edge: copy
//      shadow to char_array_o and register update=1 for that one cycle; -> HOLD.
//    HOLD (2 cycles): covers the UART's registered busy rise. uart_busy_i is
//      ignored here. -> IDLE.
//  Latency: with uart_busy_i low, update is high in the cycle after the
//    19th edge following the accepting edge (accept->ABS 1, CONV 16, PACK 1, send 1).
//  Frame stability: char_array_o changes ONLY at the send edge. The UART reads
//    later chars during transmission, so the frame must stay stable in every other state.
//  Overrun: sample_valid_i=1 while ready_o=0 -> sample dropped, drop_cnt_o+1,
//    saturates at 255. No queueing.
//  clr_i (lower priority than rst): state IDLE, update=0, drop_cnt_o=0. The
//    conversion in progress is discarded; char_array_o is unchanged. A valid
//    sample in the same cycle is not accepted.
//  Reset mid-conversion: full reset values; no strobe is emitted.
// STRUCTURE
//  mm_fmt_pkg: state enum (IDLE,ABS,CONV,PACK,WAIT_TX,HOLD); ASCII constants
//    '+','-','.','0'; function digit_to_ascii.
//  Sub-module bin2bcd_seq: start/done iterative double-dabble, DATA_W in,
//    20-bit BCD out. Top owns FSM, packing, handshake and drop counter.
// TESTING
//  1 sample 12345, busy=0 -> one strobe 19 cycles after accept, frame "+12.345\n" (char0 in [7:0]).
//  2 samples -1, -32768, 0 -> "-00.001\n", "-32.768\n", "+00.000\n"; no overflow on -32768.
//  3 uart_busy_i=1 for 100 cycles after PACK -> no strobe and old frame held;
//    busy falls -> strobe on next edge with the new frame.
//  4 valid held high for 300 cycles -> one accept per frame; drop_cnt_o saturates at 255;
//    clr_i -> drop_cnt_o=0.
//  5 clr_i, then separately rst, asserted mid-CONV -> no strobe; ready_o=1 next cycle;
//    rst restores the "+00.000\n" frame.
//  6 closed loop with uart_top, BAUD_DIV=4 -> decoded serial bytes equal the frame
//    in order char0..char7.

Source files
------------

// File: rtl/mm_fmt_pkg.sv
// Shared types and ASCII helpers for the multimeter
// sample-to-text formatter.
package mm_fmt_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ABS,
    CONV,
    PACK,
    WAIT_TX,
    HOLD
  } fmt_state_e;

  localparam int BCD_W = 20;

  localparam logic [7:0] ASC_PLUS  = 8'h2B;
  localparam logic [7:0] ASC_MINUS = 8'h2D;
  localparam logic [7:0] ASC_POINT = 8'h2E;
  localparam logic [7:0] ASC_ZERO  = 8'h30;

  function automatic logic [7:0] digit_to_ascii(
    input logic [3:0] d
  );
    return ASC_ZERO + {4'h0, d};
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble: one shift-and-adjust step
// per clock, DATA_W steps per conversion.
module bin2bcd_seq
  import mm_fmt_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              abort_i,
  input  logic              start_i,
  input  logic [DATA_W-1:0] bin_i,
  output logic              done_o,
  output logic [BCD_W-1:0]  bcd_o
);

  localparam int CNT_W = $clog2(DATA_W);

  logic [BCD_W-1:0]  bcd_q;
  logic [BCD_W-1:0]  adj_d;
  logic [DATA_W-1:0] sh_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              busy_q;
  logic              done_q;

  always_comb begin
    adj_d = bcd_q;
    for (int i = 0; i < BCD_W / 4; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5)
        adj_d[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  // The start edge performs the first step itself
  // (adjusting an all-zero BCD is a no-op).
  always_ff @(posedge clk) begin
    if (rst || abort_i) begin
      bcd_q  <= '0;
      sh_q   <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start_i) begin
        bcd_q  <= {{(BCD_W-1){1'b0}}, bin_i[DATA_W-1]};
        sh_q   <= {bin_i[DATA_W-2:0], 1'b0};
        cnt_q  <= CNT_W'(1);
        busy_q <= 1'b1;
      end else if (busy_q) begin
        bcd_q <= {adj_d[BCD_W-2:0], sh_q[DATA_W-1]};
        sh_q  <= {sh_q[DATA_W-2:0], 1'b0};
        if (cnt_q == CNT_W'(DATA_W - 1)) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end
  end

  assign done_o = done_q;
  assign bcd_o  = bcd_q;

endmodule

// File: rtl/meas_ascii_formatter.sv
// Signed mV sample -> "sDD.DDD<TERM>" ASCII frame,
// handed to the UART only while it is idle.
module meas_ascii_formatter
  import mm_fmt_pkg::*;
#(
  parameter int          DATA_W    = 16,
  parameter int          CHAR_NR   = 8,
  parameter logic [7:0]  TERM_CHAR = 8'h0A
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DATA_W-1:0]      sample_i,
  input  logic                   sample_valid_i,
  output logic                   ready_o,
  input  logic                   uart_busy_i,
  input  logic                   clr_i,
  output logic [CHAR_NR*8-1:0]   char_array_o,
  output logic                   char_array_update_o,
  output logic [7:0]             drop_cnt_o
);

  localparam logic [CHAR_NR*8-1:0] RST_FRAME = {
    TERM_CHAR, ASC_ZERO, ASC_ZERO, ASC_ZERO,
    ASC_POINT, ASC_ZERO, ASC_ZERO, ASC_PLUS
  };

  fmt_state_e            state_q;
  logic [DATA_W-1:0]     sample_q;
  logic                  neg_q;
  logic [CHAR_NR*8-1:0]  shadow_q;
  logic [CHAR_NR*8-1:0]  char_q;
  logic                  upd_q;
  logic [7:0]            drop_q;
  logic                  hold_q;

  logic [DATA_W-1:0]     mag_d;
  logic [CHAR_NR*8-1:0]  frame_d;
  logic [7:0]            drop_d;
  logic [BCD_W-1:0]      bcd;
  logic                  bcd_done;
  logic                  bcd_start;

  assign ready_o   = (state_q == IDLE);
  assign bcd_start = (state_q == ABS);

  // Unsigned magnitude: -32768 maps cleanly to 16'h8000.
  assign mag_d = sample_q[DATA_W-1] ?
                 (~sample_q + 1'b1) : sample_q;

  assign frame_d = {
    TERM_CHAR,
    digit_to_ascii(bcd[3:0]),
    digit_to_ascii(bcd[7:4]),
    digit_to_ascii(bcd[11:8]),
    ASC_POINT,
    digit_to_ascii(bcd[15:12]),
    digit_to_ascii(bcd[19:16]),
    neg_q ? ASC_MINUS : ASC_PLUS
  };

  assign drop_d = (sample_valid_i && !ready_o &&
                   drop_q != 8'hFF) ?
                  drop_q + 8'd1 : drop_q;

  bin2bcd_seq #(
    .DATA_W (DATA_W)
  ) u_bcd (
    .clk     (clk),
    .rst     (rst),
    .abort_i (clr_i),
    .start_i (bcd_start),
    .bin_i   (mag_d),
    .done_o  (bcd_done),
    .bcd_o   (bcd)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      sample_q <= '0;
      neg_q    <= 1'b0;
      shadow_q <= RST_FRAME;
      char_q   <= RST_FRAME;
      upd_q    <= 1'b0;
      drop_q   <= '0;
      hold_q   <= 1'b0;
    end else if (clr_i) begin
      state_q <= IDLE;
      upd_q   <= 1'b0;
      drop_q  <= '0;
      hold_q  <= 1'b0;
    end else begin
      upd_q  <= 1'b0;
      drop_q <= drop_d;
      unique case (state_q)
        IDLE: begin
          if (sample_valid_i) begin
            sample_q <= sample_i;
            state_q  <= ABS;
          end
        end
        ABS: begin
          neg_q   <= sample_q[DATA_W-1];
          state_q <= CONV;
        end
        CONV: begin
          if (bcd_done) state_q <= PACK;
        end
        PACK: begin
          shadow_q <= frame_d;
          state_q  <= WAIT_TX;
        end
        WAIT_TX: begin
          if (!uart_busy_i) begin
            char_q  <= shadow_q;
            upd_q   <= 1'b1;
            hold_q  <= 1'b0;
            state_q <= HOLD;
          end
        end
        HOLD: begin
          hold_q <= 1'b1;
          if (hold_q) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign char_array_o        = char_q;
  assign char_array_update_o = upd_q;
  assign drop_cnt_o          = drop_q;

endmodule
